// File: rtl/credit_pkg.sv
// credit_pkg -- shared definitions for the credit-based transmitter.
//
// Holds the largest legal credit count and the function that sizes the
// credit counter, so the top and the counter agree on widths.
package credit_pkg;

    // Largest credit count the transmitter may be configured for.
    localparam int CREDITS_MAX = 255;

    // Bits needed to hold every value from 0 up to and including credits.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter -- saturating credit counter with sticky overflow flag.
//
// Ports:
//   clk       clock, state updates on the rising edge
//   rst       synchronous active-high reset; reloads CREDITS, clears overflow
//   dec       one credit consumed this cycle (caller guarantees count != 0)
//   inc       one credit returned this cycle
//   count     current credit count, resets to CREDITS
//   overflow  sticky; set when a credit returns while count == CREDITS and
//             nothing is consumed in the same cycle
module credit_counter
    import credit_pkg::*;
#(
    parameter int CREDITS      = 4,
    parameter int CREDIT_WIDTH = credit_width(CREDITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec,
    input  logic                    inc,
    output logic [CREDIT_WIDTH-1:0] count,
    output logic                    overflow
);

    localparam logic [CREDIT_WIDTH-1:0] MAX = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ONE = CREDIT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= MAX;
            overflow <= 1'b0;
        end else if (dec && !inc) begin
            count <= count - ONE;
        end else if (inc && !dec) begin
            // A surplus return is swallowed: the count saturates and the
            // error is latched until the next reset.
            if (count == MAX) begin
                overflow <= 1'b1;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/credit_tx.sv
// credit_tx -- credit-based transmitter bridging a valid/ready source to a
// receiver that cannot apply backpressure.
//
// A transfer is accepted whenever the source is valid and a credit is held;
// each transfer consumes one credit, and the receiver hands credits back one
// pulse at a time. Returned credits are usable from the following cycle.
//
// Build option:
//   CREDIT_TX_OUT_REG_EN  defined   -> c_valid/c_data registered (latency 1)
//                         undefined -> c_valid/c_data combinational (latency 0)
//   Credit accounting is identical in both builds.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   w_valid       source has data
//   w_ready       transmitter holds at least one credit
//   w_data        source payload
//   c_valid       one-cycle pulse, c_data delivered to the receiver
//   c_data        payload to the receiver; holds last value when idle
//   c_credit      one-cycle pulse returning one credit
//   credit_count  credits currently held
//   overflow      sticky error, credit returned while already full
module credit_tx
    import credit_pkg::*;
#(
    parameter int  DATA_WIDTH   = 1,
    parameter type TYPE         = logic [DATA_WIDTH-1:0],
    parameter int  CREDITS      = 4,
    localparam int CREDIT_WIDTH = credit_width(CREDITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  TYPE                     w_data,
    output logic                    c_valid,
    output TYPE                     c_data,
    input  logic                    c_credit,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    overflow
);

    if (CREDITS < 1 || CREDITS > CREDITS_MAX) begin : g_bad_credits
        $error("credit_tx: CREDITS=%0d outside legal range 1..%0d", CREDITS, CREDITS_MAX);
    end

    logic xfer_p0;

    // w_ready comes straight from the registered count, so it never depends
    // combinationally on w_valid or c_credit.
    assign w_ready = (credit_count != '0);

    // Nothing is sent on a reset cycle, so reset never leaks a pulse.
    assign xfer_p0 = w_valid && w_ready && !rst;

    credit_counter #(
        .CREDITS      (CREDITS),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .dec      (xfer_p0),
        .inc      (c_credit),
        .count    (credit_count),
        .overflow (overflow)
    );

`ifdef CREDIT_TX_OUT_REG_EN
    // ---- stage p0 -> p1: registered output ----
    logic vld_p1;
    TYPE  data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= xfer_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer_p0) begin
            data_p1 <= w_data;
        end
    end

    assign c_valid = vld_p1;
    assign c_data  = data_p1;
`else
    // Last payload sent, replayed on c_data while c_valid is low.
    TYPE last_p0;

    always_ff @(posedge clk) begin
        if (xfer_p0) begin
            last_p0 <= w_data;
        end
    end

    assign c_valid = xfer_p0;
    assign c_data  = xfer_p0 ? w_data : last_p0;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// tb_credit_tx -- self-checking bench for credit_tx (CREDITS=4, 8-bit data).
// Honours CREDIT_TX_OUT_REG_EN to expect latency 1 instead of 0.
module tb_credit_tx;

    localparam int CREDITS = 4;
    localparam int DW      = 8;
    localparam int CW      = $clog2(CREDITS + 1);
`ifdef CREDIT_TX_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          c_valid;
    logic [DW-1:0] c_data;
    logic          c_credit;
    logic [CW-1:0] credit_count;
    logic          overflow;

    credit_tx #(
        .DATA_WIDTH (DW),
        .CREDITS    (CREDITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .c_valid      (c_valid),
        .c_data       (c_data),
        .c_credit     (c_credit),
        .credit_count (credit_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credit balance, sticky error and a payload queue.
    int            m_credits = 0;
    bit            m_ovf     = 1'b0;
    bit            m_known   = 1'b0;
    bit            m_prev_xfer = 1'b0;
    bit            m_sent_any  = 1'b0;
    logic [DW-1:0] m_last;
    logic [DW-1:0] q[$];

    // Credit bookkeeping on each active edge, from the inputs held there.
    always @(posedge clk) begin
        bit took;
        took = w_valid && (m_credits != 0) && !rst;
        if (rst) begin
            m_credits   = CREDITS;
            m_ovf       = 1'b0;
            m_known     = 1'b1;
            m_prev_xfer = 1'b0;
            m_sent_any  = 1'b0;
            q.delete();
        end else if (m_known) begin
            if (took && !c_credit) begin
                m_credits = m_credits - 1;
            end else if (c_credit && !took) begin
                if (m_credits == CREDITS) m_ovf = 1'b1;
                else m_credits = m_credits + 1;
            end
            m_prev_xfer = took;
        end
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        bit            took;
        bit            exp_v;
        logic [DW-1:0] exp_d;
        if (m_known && !rst) begin
            took  = w_valid && (m_credits != 0);
            exp_v = (LAT == 1) ? m_prev_xfer : took;
            check("w_ready", 32'(w_ready), 32'(m_credits != 0));
            check("credit_count", 32'(credit_count), 32'(m_credits));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("c_valid", 32'(c_valid), 32'(exp_v));
            if (took) q.push_back(w_data);
            if (c_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL c_valid_extra: got 1 expected 0 (no payload pending) at %0t", $time);
                end else begin
                    exp_d = q.pop_front();
                    check("c_data", 32'(c_data), 32'(exp_d));
                    m_last     = exp_d;
                    m_sent_any = 1'b1;
                end
            end else if (m_sent_any) begin
                check("c_data_hold", 32'(c_data), 32'(m_last));
            end
        end
    end

    int acc;
    int pulses;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        w_valid  = 1'b0;
        w_data   = '0;
        c_credit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(credit_count), 32'd4);
        check("rst_w_ready", 32'(w_ready), 32'd1);
        check("rst_c_valid", 32'(c_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Six cycles of w_valid with no returns: four transfers
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            w_valid = 1'b1;
            w_data  = DW'(8'h10 + i);
            @(negedge clk);
            if (w_ready) acc++;
            if (i == 4) check("ready_low_5th", 32'(w_ready), 32'd0);
        end
        tick();
        w_valid = 1'b0;
        @(negedge clk);
        check("drain_xfers", 32'(acc), 32'd4);
        check("drain_count", 32'(credit_count), 32'd0);
        check("drain_ready", 32'(w_ready), 32'd0);

        // One credit back at zero: usable next cycle, one more transfer
        tick();
        c_credit = 1'b1;
        tick();
        c_credit = 1'b0;
        @(negedge clk);
        check("ret_count", 32'(credit_count), 32'd1);
        check("ret_ready", 32'(w_ready), 32'd1);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            w_valid = 1'b1;
            w_data  = DW'(8'h77 + i);
            @(negedge clk);
            if (w_ready) acc++;
        end
        tick();
        w_valid = 1'b0;
        @(negedge clk);
        check("ret_one_xfer", 32'(acc), 32'd1);
        check("ret_stall_count", 32'(credit_count), 32'd0);

        // Bring count to 2, then transfer and return together
        tick();
        c_credit = 1'b1;
        tick();
        tick();
        c_credit = 1'b0;
        @(negedge clk);
        check("count_two", 32'(credit_count), 32'd2);
        pulses = 0;
        tick();
        w_valid  = 1'b1;
        w_data   = 8'hA5;
        c_credit = 1'b1;
        @(negedge clk);
        pulses += int'(c_valid);
        tick();
        w_valid  = 1'b0;
        c_credit = 1'b0;
        @(negedge clk);
        pulses += int'(c_valid);
        check("both_count", 32'(credit_count), 32'd2);
        check("both_pulses", 32'(pulses), 32'd1);

        // Fill to 4, transfer+return while full leaves no error
        tick();
        c_credit = 1'b1;
        tick();
        tick();
        c_credit = 1'b0;
        @(negedge clk);
        check("count_full", 32'(credit_count), 32'd4);
        tick();
        w_valid  = 1'b1;
        w_data   = 8'h3C;
        c_credit = 1'b1;
        tick();
        w_valid  = 1'b0;
        c_credit = 1'b0;
        @(negedge clk);
        check("full_both_count", 32'(credit_count), 32'd4);
        check("full_both_ovf", 32'(overflow), 32'd0);

        // Surplus return while full: saturate and latch overflow
        tick();
        c_credit = 1'b1;
        tick();
        c_credit = 1'b0;
        @(negedge clk);
        check("ovf_count", 32'(credit_count), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-operation, with a credit pulse ignored during reset
        for (int i = 0; i < 3; i++) begin
            tick();
            w_valid = 1'b1;
            w_data  = DW'(8'hC0 + i);
        end
        tick();
        w_valid  = 1'b0;
        rst      = 1'b1;
        c_credit = 1'b1;
        tick();
        rst      = 1'b0;
        c_credit = 1'b0;
        @(negedge clk);
        check("mid_rst_count", 32'(credit_count), 32'd4);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_c_valid", 32'(c_valid), 32'd0);

        // Random traffic with legal returns only
        for (int i = 0; i < 10000; i++) begin
            tick();
            w_valid  = 1'($urandom_range(0, 1));
            w_data   = DW'($urandom);
            c_credit = (m_credits < CREDITS) && ($urandom_range(0, 2) == 0);
        end
        tick();
        w_valid  = 1'b0;
        c_credit = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("rand_no_ovf", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
